operand_sel_stage: RTL and testbench
====================================

# operand_sel_stage

Parametrised successor to the ALU source-A selector. It selects one of NSRC operand sources and captures the result in a two-entry skid buffer with valid/ready handshakes on both sides, so multi-cycle units (mult/div) receive an operand that stays stable while they are busy. The block sits between the datapath source registers (PC, A, MDR, ALUOut, …) and the ALU / multi-cycle unit operand ports.

## Interface
- WIDTH, 32, operand width in bits
- NSRC, 4, number of selectable sources (≥2)
- SEL_W, max(1, $clog2(NSRC)), select width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- sel  in  SEL_W  source index
- src  in  NSRC*WIDTH  packed sources; source i = src[i*WIDTH +: WIDTH]
- in_valid  in  1  sel/src valid this cycle
- in_ready  out  1  buffer can accept
- flush  in  1  discard all buffered entries
- out_data  out  WIDTH  head-entry operand
- out_sel  out  SEL_W  sel value captured with head entry
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry
- sel_err  out  1  sticky: an out-of-range sel was accepted

## Operation
- Clocking: one clock; reset is synchronous and active-high.
- Accept = in_valid && in_ready; pop = out_valid && out_ready.
- Captured entry = {src[sel], sel} when sel < NSRC; when sel ≥ NSRC (only possible if NSRC is not a power of 2), capture data 0, keep sel, and set sel_err.
- sel_err stays set until reset; flush does not clear it.
- States (shared enum): EMPTY (0 entries), ONE (1), TWO (2).
  - EMPTY: accept → ONE, entry written to head.
  - ONE: accept & !pop → TWO (entry to tail); pop & !accept → EMPTY; accept & pop → ONE, head overwritten with the new entry.
  - TWO: in_ready=0; pop → ONE, tail moves to head.
- in_ready = (state != TWO) && !reset. It is a function of state only; there is no combinational path from out_ready.
- out_valid = (state != EMPTY).
- flush: highest priority below reset; next state EMPTY, and any accept in the same cycle is dropped. in_ready is unaffected by flush in that cycle.
- Entry order is strictly FIFO. No entry is duplicated or lost except on flush or reset.
- Reset values: state EMPTY, out_valid 0, out_data 0, out_sel 0, sel_err 0, tail 0. in_ready reads 0 while reset is high and 1 in the first cycle after reset.
- out_data and out_sel hold their last value when EMPTY; consumers must not rely on them.

## Timing
- Latency: an accept at edge N gives out_valid=1 with data after edge N (visible in cycle N+1).
- Throughput: 1 entry per cycle in steady state with out_ready=1.
- out_data, out_sel and out_valid are register outputs. in_ready is decoded from the state register only.
- Stall of 1 cycle: the buffer fills to TWO and in_ready drops the cycle after the second accept. It rises the cycle after the first pop.
- Reset or flush mid-transfer: entries are gone by the next cycle; out_valid=0 then.

## Structure
- Package operand_sel_pkg:
  - state enum {EMPTY, ONE, TWO}
  - localparam default WIDTH/NSRC
  - a function for SEL_W
- Sub-module operand_mux_n (combinational, parametrised WIDTH/NSRC):
  - returns the selected word and an out_of_range flag
  - instantiated once
- Top-level holds the head/tail registers, the state register, and sel_err.

## Test plan
- WIDTH=32, NSRC=4, out_ready=1: accept sel=2 with src2=0xDEADBEEF → next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2; back-to-back sel=0,1,3 stream at 1/cycle in order.
- out_ready=0, three consecutive in_valid → first two accepted, in_ready=0 from cycle 2, third held. Raise out_ready → data pops in order, and the third is accepted the cycle after the first pop.
- State ONE with accept and pop in the same cycle → state stays ONE, out_data is the new entry, no entry lost.
- NSRC=3, SEL_W=2, accept sel=3 → out_data=0, out_sel=3, sel_err=1. sel_err stays 1 after flush and clears only on reset.
- State TWO, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, the flushed-cycle input is not captured.
- reset asserted while in state TWO → next cycle all outputs at reset values; in_ready=0 while reset is high, 1 after it drops.

Source files
------------

// File: rtl/operand_sel_pkg.sv
// Shared types and helpers for the operand select / skid-buffer stage.
//   state_e    : buffer occupancy state (EMPTY, ONE, TWO)
//   DEF_WIDTH  : default operand width
//   DEF_NSRC   : default number of operand sources
//   sel_w()    : select width for a given source count (at least 1 bit)
package operand_sel_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_NSRC  = 4;

   // Select width: ceil(log2(n)), never below one bit.
   function automatic int unsigned sel_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/operand_mux_n.sv
// Combinational N-way operand selector.
//   sel          : source index
//   src          : packed sources, source i = src[i*WIDTH +: WIDTH]
//   data         : selected word (0 when sel is out of range)
//   out_of_range : sel >= NSRC
module operand_mux_n
   import operand_sel_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned NSRC  = DEF_NSRC,
   localparam int unsigned SEL_W = sel_w(NSRC)
) (
   input  logic [SEL_W-1:0]      sel,
   input  logic [NSRC*WIDTH-1:0] src,
   output logic [WIDTH-1:0]      data,
   output logic                  out_of_range
);

   // Only reachable when NSRC is not a power of two.
   assign out_of_range = (32'(sel) >= NSRC);

   always_comb begin
      data = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (sel == SEL_W'(i)) begin
            data = src[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/operand_sel_stage.sv
// Operand source select feeding a two-entry skid buffer.
//   clk, reset         : clock, synchronous active-high reset
//   sel, src, in_valid : source index, packed sources, input valid
//   in_ready           : buffer can accept (state only, no path from out_ready)
//   flush              : drop all buffered entries and any same-cycle accept
//   out_data, out_sel  : head entry operand and its captured select
//   out_valid          : head entry valid
//   out_ready          : consumer takes head entry
//   sel_err            : sticky, an out-of-range select was captured
module operand_sel_stage
   import operand_sel_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned NSRC  = DEF_NSRC,
   localparam int unsigned SEL_W = sel_w(NSRC)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SEL_W-1:0]      sel,
   input  logic [NSRC*WIDTH-1:0] src,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_sel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sel_err
);

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       head_data_q, head_data_d;
   logic [SEL_W-1:0]       head_sel_q, head_sel_d;
   logic [WIDTH-1:0]       tail_data_q, tail_data_d;
   logic [SEL_W-1:0]       tail_sel_q, tail_sel_d;
   logic                   sel_err_q, sel_err_d;

   logic [WIDTH-1:0]       mux_data;
   logic                   mux_oor;
   logic                   accept;
   logic                   pop;

   operand_mux_n #(
      .WIDTH (WIDTH),
      .NSRC  (NSRC)
   ) u_mux (
      .sel          (sel),
      .src          (src),
      .data         (mux_data),
      .out_of_range (mux_oor)
   );

   assign in_ready  = (state_q != TWO) && !reset;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = head_data_q;
   assign out_sel   = head_sel_q;
   assign sel_err   = sel_err_q;

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   // Next-state and buffer update; flush overrides everything below reset.
   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_sel_d  = head_sel_q;
      tail_data_d = tail_data_q;
      tail_sel_d  = tail_sel_q;
      sel_err_d   = sel_err_q;

      if (flush) begin
         state_d = EMPTY;
      end else begin
         if (accept && mux_oor) begin
            sel_err_d = 1'b1;
         end
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d     = ONE;
                  head_data_d = mux_data;
                  head_sel_d  = sel;
               end
            end
            ONE: begin
               if (accept && !pop) begin
                  state_d     = TWO;
                  tail_data_d = mux_data;
                  tail_sel_d  = sel;
               end else if (!accept && pop) begin
                  state_d = EMPTY;
               end else if (accept && pop) begin
                  head_data_d = mux_data;
                  head_sel_d  = sel;
               end
            end
            TWO: begin
               if (pop) begin
                  state_d     = ONE;
                  head_data_d = tail_data_q;
                  head_sel_d  = tail_sel_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // State, buffer and sticky error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         head_data_q <= '0;
         head_sel_q  <= '0;
         tail_data_q <= '0;
         tail_sel_q  <= '0;
         sel_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_data_q <= head_data_d;
         head_sel_q  <= head_sel_d;
         tail_data_q <= tail_data_d;
         tail_sel_q  <= tail_sel_d;
         sel_err_q   <= sel_err_d;
      end
   end

endmodule

// File: tb/tb_operand_sel_stage.sv
// Directed self-checking bench for operand_sel_stage (NSRC=4 and NSRC=3 instances).
module tb_operand_sel_stage;

   localparam int unsigned WIDTH = 32;

   logic clk = 1'b0;
   logic reset;

   // NSRC=4 instance signals
   logic [1:0]        sel4;
   logic [4*WIDTH-1:0] src4;
   logic              in_valid4, in_ready4, flush4;
   logic [WIDTH-1:0]  out_data4;
   logic [1:0]        out_sel4;
   logic              out_valid4, out_ready4, sel_err4;

   // NSRC=3 instance signals
   logic [1:0]        sel3;
   logic [3*WIDTH-1:0] src3;
   logic              in_valid3, in_ready3, flush3;
   logic [WIDTH-1:0]  out_data3;
   logic [1:0]        out_sel3;
   logic              out_valid3, out_ready3, sel_err3;

   int cmps = 0;
   int errs = 0;

   localparam logic [31:0] S0 = 32'hA0A0_A0A0;
   localparam logic [31:0] S1 = 32'hB1B1_B1B1;
   localparam logic [31:0] S2 = 32'hDEAD_BEEF;
   localparam logic [31:0] S3 = 32'hC3C3_C3C3;

   always #5 clk = ~clk;

   operand_sel_stage #(.WIDTH(WIDTH), .NSRC(4)) u_dut4 (
      .clk       (clk),
      .reset     (reset),
      .sel       (sel4),
      .src       (src4),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .flush     (flush4),
      .out_data  (out_data4),
      .out_sel   (out_sel4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .sel_err   (sel_err4)
   );

   operand_sel_stage #(.WIDTH(WIDTH), .NSRC(3)) u_dut3 (
      .clk       (clk),
      .reset     (reset),
      .sel       (sel3),
      .src       (src3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .flush     (flush3),
      .out_data  (out_data3),
      .out_sel   (out_sel3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .sel_err   (sel_err3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmps++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      sel4       = '0;
      src4       = {S3, S2, S1, S0};
      in_valid4  = 1'b0;
      flush4     = 1'b0;
      out_ready4 = 1'b1;
      sel3       = '0;
      src3       = {S2, S1, S0};
      in_valid3  = 1'b0;
      flush3     = 1'b0;
      out_ready3 = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_in_ready", 64'(in_ready4), 64'd0);
      chk("rst_out_valid", 64'(out_valid4), 64'd0);
      chk("rst_out_data", 64'(out_data4), 64'd0);
      chk("rst_out_sel", 64'(out_sel4), 64'd0);
      chk("rst_sel_err", 64'(sel_err4), 64'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready4), 64'd1);

      // Single accept, then back-to-back stream with out_ready=1
      in_valid4 = 1'b1; sel4 = 2'd2;
      step();
      chk("lat_valid", 64'(out_valid4), 64'd1);
      chk("lat_data", 64'(out_data4), 64'(S2));
      chk("lat_sel", 64'(out_sel4), 64'd2);
      sel4 = 2'd0;
      step();
      chk("b2b0_data", 64'(out_data4), 64'(S0));
      chk("b2b0_sel", 64'(out_sel4), 64'd0);
      sel4 = 2'd1;
      step();
      chk("b2b1_data", 64'(out_data4), 64'(S1));
      sel4 = 2'd3;
      step();
      chk("b2b3_data", 64'(out_data4), 64'(S3));
      chk("b2b3_sel", 64'(out_sel4), 64'd3);
      chk("b2b_in_ready", 64'(in_ready4), 64'd1);
      in_valid4 = 1'b0;
      step();
      chk("drain_valid", 64'(out_valid4), 64'd0);

      // Stall: fill to TWO, third input held, then drain in order
      out_ready4 = 1'b0;
      in_valid4 = 1'b1; sel4 = 2'd0;
      step();
      chk("stall1_in_ready", 64'(in_ready4), 64'd1);
      chk("stall1_data", 64'(out_data4), 64'(S0));
      sel4 = 2'd1;
      step();
      chk("stall2_in_ready", 64'(in_ready4), 64'd0);
      chk("stall2_valid", 64'(out_valid4), 64'd1);
      chk("stall2_data", 64'(out_data4), 64'(S0));
      sel4 = 2'd2;
      step();
      chk("stall3_in_ready", 64'(in_ready4), 64'd0);
      chk("stall3_data", 64'(out_data4), 64'(S0));
      chk("stall3_sel", 64'(out_sel4), 64'd0);
      out_ready4 = 1'b1;
      step();
      chk("pop1_data", 64'(out_data4), 64'(S1));
      chk("pop1_sel", 64'(out_sel4), 64'd1);
      chk("pop1_in_ready", 64'(in_ready4), 64'd1);
      // ONE with accept and pop together: head replaced, state stays ONE
      step();
      chk("pop2_data", 64'(out_data4), 64'(S2));
      chk("pop2_sel", 64'(out_sel4), 64'd2);
      chk("pop2_valid", 64'(out_valid4), 64'd1);
      chk("pop2_in_ready", 64'(in_ready4), 64'd1);
      in_valid4 = 1'b0;
      step();
      chk("pop3_valid", 64'(out_valid4), 64'd0);

      // Flush in TWO together with in_valid
      out_ready4 = 1'b0;
      in_valid4 = 1'b1; sel4 = 2'd0;
      step();
      sel4 = 2'd1;
      step();
      chk("fl_two_in_ready", 64'(in_ready4), 64'd0);
      flush4 = 1'b1; sel4 = 2'd3;
      step();
      flush4 = 1'b0; in_valid4 = 1'b0;
      chk("fl_two_valid", 64'(out_valid4), 64'd0);
      chk("fl_two_in_ready1", 64'(in_ready4), 64'd1);

      // Flush in EMPTY with an accept: the accept is dropped
      in_valid4 = 1'b1; flush4 = 1'b1; sel4 = 2'd2;
      step();
      flush4 = 1'b0; in_valid4 = 1'b0;
      chk("fl_acc_valid", 64'(out_valid4), 64'd0);
      out_ready4 = 1'b1;
      step();
      chk("fl_acc_valid2", 64'(out_valid4), 64'd0);

      // Flush in ONE with an accept: both dropped
      in_valid4 = 1'b1; sel4 = 2'd3; out_ready4 = 1'b0;
      step();
      chk("fl_one_pre", 64'(out_data4), 64'(S3));
      flush4 = 1'b1; sel4 = 2'd1;
      step();
      flush4 = 1'b0; in_valid4 = 1'b0;
      chk("fl_one_valid", 64'(out_valid4), 64'd0);

      // Out-of-range select on NSRC=3 instance
      in_valid3 = 1'b1; sel3 = 2'd3;
      step();
      chk("oor_valid", 64'(out_valid3), 64'd1);
      chk("oor_data", 64'(out_data3), 64'd0);
      chk("oor_sel", 64'(out_sel3), 64'd3);
      chk("oor_err", 64'(sel_err3), 64'd1);
      sel3 = 2'd1;
      step();
      chk("n3_in_ready", 64'(in_ready3), 64'd0);
      in_valid3 = 1'b0; out_ready3 = 1'b1;
      step();
      chk("n3_tail_data", 64'(out_data3), 64'(S1));
      chk("n3_tail_sel", 64'(out_sel3), 64'd1);
      out_ready3 = 1'b0; flush3 = 1'b1;
      step();
      flush3 = 1'b0;
      chk("n3_fl_valid", 64'(out_valid3), 64'd0);
      chk("n3_fl_err", 64'(sel_err3), 64'd1);

      // Reset while NSRC=4 instance is in TWO
      in_valid4 = 1'b1; sel4 = 2'd2; out_ready4 = 1'b0;
      step();
      sel4 = 2'd3;
      step();
      in_valid4 = 1'b0;
      chk("two_pre_in_ready", 64'(in_ready4), 64'd0);
      chk("two_pre_data", 64'(out_data4), 64'(S2));
      reset = 1'b1;
      #1;
      chk("rst_hi_in_ready", 64'(in_ready4), 64'd0);
      step();
      chk("rst2_valid", 64'(out_valid4), 64'd0);
      chk("rst2_data", 64'(out_data4), 64'd0);
      chk("rst2_sel", 64'(out_sel4), 64'd0);
      chk("rst2_in_ready", 64'(in_ready4), 64'd0);
      chk("rst2_err3", 64'(sel_err3), 64'd0);
      chk("rst2_data3", 64'(out_data3), 64'd0);
      reset = 1'b0;
      #1;
      chk("rst2_in_ready_after", 64'(in_ready4), 64'd1);
      step();
      chk("rst2_idle_valid", 64'(out_valid4), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
